// File: rtl/spi_response_transmitter_pkg.sv
// Shared definitions for the SD-style SPI response path: FSM states,
// response-type encodings, response lengths and the N_CR filler pattern.
package spi_response_transmitter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_NCR      = 3'd1,
        ST_SHIFT    = 3'd2,
        ST_BUSYWAIT = 3'd3,
        ST_DONE     = 3'd4
    } tx_state_t;

    localparam logic [1:0] RESP_R1   = 2'd0;
    localparam logic [1:0] RESP_R3R7 = 2'd1;
    localparam logic [1:0] RESP_R1B  = 2'd2;

    localparam int RESP_LEN_R1   = 8;
    localparam int RESP_LEN_R3R7 = 40;

    localparam logic [7:0] FILLER_BYTE = 8'hFF;

    // Encoding 3 is undefined on the wire and is sent as a plain R1.
    function automatic logic [1:0] normalise_type(input logic [1:0] rtype);
        if (rtype == RESP_R3R7 || rtype == RESP_R1B) begin
            return rtype;
        end
        return RESP_R1;
    endfunction

    function automatic logic [5:0] last_bit_index(input logic [1:0] rtype);
        if (rtype == RESP_R3R7) begin
            return 6'(RESP_LEN_R3R7 - 1);
        end
        return 6'(RESP_LEN_R1 - 1);
    endfunction

endpackage

// File: rtl/spi_edge_detector.sv
// Brings the host SPI clock and chip select into the system clock domain
// and produces single-cycle pulses on each synchronised clock edge.
module spi_edge_detector #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic spi_clk,
    input  logic spi_cs,
    output logic clk_sync,
    output logic cs_sync,
    output logic fall,
    output logic rise
);

    logic [SYNC_STAGES-1:0] clk_pipe;
    logic [SYNC_STAGES-1:0] cs_pipe;
    logic                   clk_prev;

    // CS resets high so a freshly reset card looks deselected.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clk_pipe <= '0;
            cs_pipe  <= '1;
            clk_prev <= 1'b0;
        end else begin
            clk_pipe <= SYNC_STAGES'({clk_pipe, spi_clk});
            cs_pipe  <= SYNC_STAGES'({cs_pipe, spi_cs});
            clk_prev <= clk_pipe[SYNC_STAGES-1];
        end
    end

    assign clk_sync = clk_pipe[SYNC_STAGES-1];
    assign cs_sync  = cs_pipe[SYNC_STAGES-1];
    assign fall     = clk_prev & ~clk_sync;
    assign rise     = ~clk_prev & clk_sync;

endmodule

// File: rtl/spi_response_transmitter.sv
// Card-side SPI response serialiser: N_CR filler, R1 / R3 / R7 / R1b
// responses MSB first on io_SPI_DO, updated on host SPI clock falls.
module spi_response_transmitter
    import spi_response_transmitter_pkg::*;
#(
    parameter int NCR_BYTES   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_SPI_CLK,
    input  logic        io_SPI_CS,
    output logic        io_SPI_DO,
    input  logic        io_Start,
    input  logic [1:0]  io_ResponseType,
    input  logic [7:0]  io_R1,
    input  logic [31:0] io_Payload,
    input  logic        io_CardBusy,
    output logic        io_Busy,
    output logic        io_Done,
    output logic        io_Aborted
);

    localparam logic [2:0] LAST_NCR_BYTE = 3'(NCR_BYTES - 1);

    tx_state_t   state_q, state_d;
    logic [39:0] shift_q, shift_d;
    logic [5:0]  bit_q, bit_d;
    logic [2:0]  byte_q, byte_d;
    logic [1:0]  type_q, type_d;
    logic        do_q, do_d;
    logic        done_q, done_d;
    logic        aborted_q, aborted_d;

    logic spi_clk_sync_unused;
    logic spi_rise_unused;
    logic cs_sync;
    logic spi_fall;

    spi_edge_detector #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge (
        .clock    (clock),
        .reset    (reset),
        .spi_clk  (io_SPI_CLK),
        .spi_cs   (io_SPI_CS),
        .clk_sync (spi_clk_sync_unused),
        .cs_sync  (cs_sync),
        .fall     (spi_fall),
        .rise     (spi_rise_unused)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_q     <= '0;
            byte_q    <= '0;
            type_q    <= RESP_R1;
            do_q      <= 1'b1;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            type_q    <= type_d;
            do_q      <= do_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    // Deselection wins over any edge arriving in the same cycle.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        type_d    = type_q;
        do_d      = do_q;
        done_d    = 1'b0;
        aborted_d = 1'b0;

        if (state_q != ST_IDLE && cs_sync) begin
            state_d   = ST_IDLE;
            do_d      = 1'b1;
            aborted_d = 1'b1;
            bit_d     = '0;
            byte_d    = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (io_Start && !cs_sync) begin
                        type_d  = normalise_type(io_ResponseType);
                        shift_d = {io_R1, (io_ResponseType == RESP_R3R7) ? io_Payload : 32'h0};
                        bit_d   = '0;
                        byte_d  = '0;
                        do_d    = 1'b1;
                        state_d = ST_NCR;
                    end
                end

                ST_NCR: begin
                    if (spi_fall) begin
                        if (bit_q[2:0] == 3'd7) begin
                            bit_d = '0;
                            if (byte_q == LAST_NCR_BYTE) begin
                                byte_d  = '0;
                                do_d    = shift_q[39];
                                shift_d = {shift_q[38:0], 1'b0};
                                state_d = ST_SHIFT;
                            end else begin
                                byte_d = byte_q + 3'd1;
                                do_d   = FILLER_BYTE[3'd7 - bit_q[2:0]];
                            end
                        end else begin
                            bit_d = bit_q + 6'd1;
                            do_d  = FILLER_BYTE[3'd7 - bit_q[2:0]];
                        end
                    end
                end

                ST_SHIFT: begin
                    if (spi_fall) begin
                        if (bit_q == last_bit_index(type_q)) begin
                            bit_d = '0;
                            // R1b starts its busy token on the very fall that ends R1.
                            if (type_q == RESP_R1B && io_CardBusy) begin
                                do_d    = 1'b0;
                                state_d = ST_BUSYWAIT;
                            end else begin
                                do_d    = 1'b1;
                                state_d = ST_DONE;
                            end
                        end else begin
                            bit_d   = bit_q + 6'd1;
                            do_d    = shift_q[39];
                            shift_d = {shift_q[38:0], 1'b0};
                        end
                    end
                end

                ST_BUSYWAIT: begin
                    if (spi_fall) begin
                        if (io_CardBusy) begin
                            do_d = 1'b0;
                        end else begin
                            do_d    = 1'b1;
                            state_d = ST_DONE;
                        end
                    end
                end

                ST_DONE: begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end

                default: begin
                    state_d = ST_IDLE;
                    do_d    = 1'b1;
                end
            endcase
        end
    end

    assign io_SPI_DO  = do_q;
    assign io_Busy    = (state_q != ST_IDLE);
    assign io_Done    = done_q;
    assign io_Aborted = aborted_q;

endmodule

// File: tb/tb_spi_response_transmitter.sv
// Self-checking bench for spi_response_transmitter: a bit-level scoreboard
// of expected DO values compared after every host SPI clock fall.
module tb_spi_response_transmitter;

    localparam int NCR_BYTES   = 1;
    localparam int SYNC_STAGES = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        io_SPI_CLK = 1'b0;
    logic        io_SPI_CS = 1'b1;
    logic        io_SPI_DO;
    logic        io_Start = 1'b0;
    logic [1:0]  io_ResponseType = 2'd0;
    logic [7:0]  io_R1 = 8'h00;
    logic [31:0] io_Payload = 32'h0;
    logic        io_CardBusy = 1'b0;
    logic        io_Busy;
    logic        io_Done;
    logic        io_Aborted;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int abort_cnt = 0;
    logic exp_q[$];

    spi_response_transmitter #(
        .NCR_BYTES   (NCR_BYTES),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .io_SPI_CLK      (io_SPI_CLK),
        .io_SPI_CS       (io_SPI_CS),
        .io_SPI_DO       (io_SPI_DO),
        .io_Start        (io_Start),
        .io_ResponseType (io_ResponseType),
        .io_R1           (io_R1),
        .io_Payload      (io_Payload),
        .io_CardBusy     (io_CardBusy),
        .io_Busy         (io_Busy),
        .io_Done         (io_Done),
        .io_Aborted      (io_Aborted)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (io_Done === 1'b1) done_cnt = done_cnt + 1;
        if (io_Aborted === 1'b1) abort_cnt = abort_cnt + 1;
    end

    // Reference model: filler, then response bits MSB first, busy token, idle-high.
    function automatic void push_expected(input logic [1:0] rtype, input logic [7:0] r1,
                                          input logic [31:0] payload, input int busy_falls);
        logic [39:0] data;
        int nbits;
        data  = {r1, payload};
        nbits = (rtype == 2'd1) ? 40 : 8;
        for (int i = 0; i < NCR_BYTES * 8 - 1; i++) exp_q.push_back(1'b1);
        for (int i = 0; i < nbits; i++) exp_q.push_back(data[39 - i]);
        if (rtype == 2'd2) begin
            for (int i = 0; i < busy_falls; i++) exp_q.push_back(1'b0);
        end
        exp_q.push_back(1'b1);
    endfunction

    // One full SPI mode-0 period; returns near the end of the low phase.
    task automatic spi_fall();
        io_SPI_CLK = 1'b1;
        #80;
        io_SPI_CLK = 1'b0;
        #80;
    endtask

    task automatic pulse_start(input logic [1:0] rtype, input logic [7:0] r1, input logic [31:0] payload);
        io_ResponseType = rtype;
        io_R1           = r1;
        io_Payload      = payload;
        io_Start        = 1'b1;
        #10;
        io_Start        = 1'b0;
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        reset = 1'b0;
        #20;
        checks++; if (io_SPI_DO !== 1'b1) begin errors++; $display("[TB] FAIL reset_do: got %b want 1", io_SPI_DO); end
        checks++; if (io_Busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", io_Busy); end
        checks++; if (io_Done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b want 0", io_Done); end
        checks++; if (io_Aborted !== 1'b0) begin errors++; $display("[TB] FAIL reset_aborted: got %b want 0", io_Aborted); end
        reset = 1'b1;
        io_SPI_CS = 1'b0;
        #60;
    endtask

    task automatic test_r1();
        int n, d0, a0;
        logic e;
        $display("[TB] test_r1");
        d0 = done_cnt; a0 = abort_cnt;
        push_expected(2'd0, 8'h01, 32'h0, 0);
        pulse_start(2'd0, 8'h01, 32'hDEADBEEF);
        checks++; if (io_Busy !== 1'b1) begin errors++; $display("[TB] FAIL r1_busy_rise: got %b want 1", io_Busy); end
        n = exp_q.size();
        for (int i = 1; i <= n; i++) begin
            spi_fall();
            e = exp_q.pop_front();
            checks++; if (io_SPI_DO !== e) begin errors++; $display("[TB] FAIL r1_do fall %0d: got %b want %b", i, io_SPI_DO, e); end
            if (i < n && io_Busy !== 1'b1) begin checks++; errors++; $display("[TB] FAIL r1_busy fall %0d: got %b want 1", i, io_Busy); end
        end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("[TB] FAIL r1_done_pulses: got %0d want 1", done_cnt - d0); end
        checks++; if (abort_cnt - a0 != 0) begin errors++; $display("[TB] FAIL r1_abort_pulses: got %0d want 0", abort_cnt - a0); end
        checks++; if (io_Busy !== 1'b0) begin errors++; $display("[TB] FAIL r1_busy_end: got %b want 0", io_Busy); end
    endtask

    task automatic test_r7();
        int n, d0;
        logic e;
        $display("[TB] test_r7");
        d0 = done_cnt;
        push_expected(2'd1, 8'h01, 32'h000001AA, 0);
        pulse_start(2'd1, 8'h01, 32'h000001AA);
        n = exp_q.size();
        checks++; if (n != 48) begin errors++; $display("[TB] FAIL r7_length: got %0d want 48", n); end
        for (int i = 1; i <= n; i++) begin
            spi_fall();
            e = exp_q.pop_front();
            checks++; if (io_SPI_DO !== e) begin errors++; $display("[TB] FAIL r7_do fall %0d: got %b want %b", i, io_SPI_DO, e); end
            if (i == n - 1) begin
                checks++; if (done_cnt - d0 != 0) begin errors++; $display("[TB] FAIL r7_early_done: got %0d want 0", done_cnt - d0); end
            end
        end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("[TB] FAIL r7_done_pulses: got %0d want 1", done_cnt - d0); end
        checks++; if (io_Busy !== 1'b0) begin errors++; $display("[TB] FAIL r7_busy_end: got %b want 0", io_Busy); end
    endtask

    task automatic test_r1b_busy();
        int n, d0;
        logic e;
        $display("[TB] test_r1b_busy");
        d0 = done_cnt;
        push_expected(2'd2, 8'h00, 32'h0, 20);
        pulse_start(2'd2, 8'h00, 32'h0);
        n = exp_q.size();
        for (int i = 1; i <= n; i++) begin
            io_CardBusy = (i >= NCR_BYTES * 8 + 8 && i < NCR_BYTES * 8 + 28);
            spi_fall();
            e = exp_q.pop_front();
            checks++; if (io_SPI_DO !== e) begin errors++; $display("[TB] FAIL r1b_do fall %0d: got %b want %b", i, io_SPI_DO, e); end
            if (i < n && io_Busy !== 1'b1) begin checks++; errors++; $display("[TB] FAIL r1b_busy fall %0d: got %b want 1", i, io_Busy); end
        end
        io_CardBusy = 1'b0;
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("[TB] FAIL r1b_done_pulses: got %0d want 1", done_cnt - d0); end
        checks++; if (io_Busy !== 1'b0) begin errors++; $display("[TB] FAIL r1b_busy_end: got %b want 0", io_Busy); end
    endtask

    task automatic test_abort();
        int n, d0, a0;
        logic e;
        $display("[TB] test_abort");
        d0 = done_cnt; a0 = abort_cnt;
        push_expected(2'd0, 8'h00, 32'h0, 0);
        pulse_start(2'd0, 8'h00, 32'h0);
        for (int i = 1; i <= 12; i++) begin
            spi_fall();
            e = exp_q.pop_front();
            checks++; if (io_SPI_DO !== e) begin errors++; $display("[TB] FAIL abort_pre_do fall %0d: got %b want %b", i, io_SPI_DO, e); end
        end
        exp_q.delete();
        io_SPI_CS = 1'b1;
        #100;
        checks++; if (abort_cnt - a0 != 1) begin errors++; $display("[TB] FAIL abort_pulses: got %0d want 1", abort_cnt - a0); end
        checks++; if (io_SPI_DO !== 1'b1) begin errors++; $display("[TB] FAIL abort_do: got %b want 1", io_SPI_DO); end
        checks++; if (io_Busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy: got %b want 0", io_Busy); end
        for (int i = 0; i < 8; i++) spi_fall();
        checks++; if (done_cnt - d0 != 0) begin errors++; $display("[TB] FAIL abort_done_suppressed: got %0d want 0", done_cnt - d0); end
        io_SPI_CS = 1'b0;
        #60;
        d0 = done_cnt;
        push_expected(2'd0, 8'hA5, 32'h0, 0);
        pulse_start(2'd0, 8'hA5, 32'h0);
        n = exp_q.size();
        for (int i = 1; i <= n; i++) begin
            spi_fall();
            e = exp_q.pop_front();
            checks++; if (io_SPI_DO !== e) begin errors++; $display("[TB] FAIL abort_retry_do fall %0d: got %b want %b", i, io_SPI_DO, e); end
        end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("[TB] FAIL abort_retry_done: got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_ignored_starts();
        int n, d0;
        logic e;
        $display("[TB] test_ignored_starts");
        io_SPI_CS = 1'b1;
        #60;
        pulse_start(2'd0, 8'h00, 32'h0);
        #40;
        checks++; if (io_Busy !== 1'b0) begin errors++; $display("[TB] FAIL cs_high_start_busy: got %b want 0", io_Busy); end
        spi_fall();
        checks++; if (io_SPI_DO !== 1'b1) begin errors++; $display("[TB] FAIL cs_high_start_do: got %b want 1", io_SPI_DO); end
        io_SPI_CS = 1'b0;
        #60;
        d0 = done_cnt;
        push_expected(2'd0, 8'h5A, 32'h0, 0);
        pulse_start(2'd0, 8'h5A, 32'h0);
        n = exp_q.size();
        for (int i = 1; i <= n; i++) begin
            if (i == 11) pulse_start(2'd1, 8'hFF, 32'h0);
            spi_fall();
            e = exp_q.pop_front();
            checks++; if (io_SPI_DO !== e) begin errors++; $display("[TB] FAIL midstart_do fall %0d: got %b want %b", i, io_SPI_DO, e); end
        end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("[TB] FAIL midstart_done: got %0d want 1", done_cnt - d0); end
        d0 = done_cnt;
        push_expected(2'd3, 8'hC3, 32'h12345678, 0);
        pulse_start(2'd3, 8'hC3, 32'h12345678);
        n = exp_q.size();
        for (int i = 1; i <= n; i++) begin
            spi_fall();
            e = exp_q.pop_front();
            checks++; if (io_SPI_DO !== e) begin errors++; $display("[TB] FAIL type3_do fall %0d: got %b want %b", i, io_SPI_DO, e); end
        end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("[TB] FAIL type3_done: got %0d want 1", done_cnt - d0); end
        checks++; if (io_Busy !== 1'b0) begin errors++; $display("[TB] FAIL type3_busy_end: got %b want 0", io_Busy); end
    endtask

    task automatic test_async_reset();
        int n, d0;
        logic e;
        $display("[TB] test_async_reset");
        push_expected(2'd0, 8'h00, 32'h0, 0);
        pulse_start(2'd0, 8'h00, 32'h0);
        for (int i = 1; i <= 10; i++) begin
            spi_fall();
            e = exp_q.pop_front();
            checks++; if (io_SPI_DO !== e) begin errors++; $display("[TB] FAIL areset_pre_do fall %0d: got %b want %b", i, io_SPI_DO, e); end
        end
        exp_q.delete();
        reset = 1'b0;
        #2;
        checks++; if (io_SPI_DO !== 1'b1) begin errors++; $display("[TB] FAIL areset_do: got %b want 1", io_SPI_DO); end
        checks++; if (io_Busy !== 1'b0) begin errors++; $display("[TB] FAIL areset_busy: got %b want 0", io_Busy); end
        checks++; if (io_Done !== 1'b0) begin errors++; $display("[TB] FAIL areset_done: got %b want 0", io_Done); end
        checks++; if (io_Aborted !== 1'b0) begin errors++; $display("[TB] FAIL areset_aborted: got %b want 0", io_Aborted); end
        #28;
        reset = 1'b1;
        #60;
        d0 = done_cnt;
        push_expected(2'd0, 8'h81, 32'h0, 0);
        pulse_start(2'd0, 8'h81, 32'h0);
        n = exp_q.size();
        for (int i = 1; i <= n; i++) begin
            spi_fall();
            e = exp_q.pop_front();
            checks++; if (io_SPI_DO !== e) begin errors++; $display("[TB] FAIL areset_retry_do fall %0d: got %b want %b", i, io_SPI_DO, e); end
        end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("[TB] FAIL areset_retry_done: got %0d want 1", done_cnt - d0); end
    endtask

    initial begin
        test_reset();
        test_r1();
        test_r7();
        test_r1b_busy();
        test_abort();
        test_ignored_starts();
        test_async_reset();
        #100;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
